// File: rtl/uart_tx.sv
// uart_tx: 8-bit LSB-first UART transmitter with a byte FIFO,
// optional parity and one or two stop bits.
module uart_tx #(
  parameter int CLKS_PER_BIT = 427,
  parameter int FIFO_DEPTH   = 4,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] datain,
  input  logic       EnableIn,
  output logic       Tx,
  output logic       busy,
  output logic       full,
  output logic       overflow,
  output logic       EnableOut
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [15:0] CNT_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] DEPTH = CW'(FIFO_DEPTH);
  localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);
  localparam logic PAR_ODD = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t        state_q, state_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          wr_en;
  logic          pop;
  logic          bit_end;
  logic          frame_end;

  // A write while full is dropped even if a pop frees a slot.
  assign full     = (count_q == DEPTH);
  assign wr_en    = EnableIn && !full;
  assign overflow = EnableIn && full;
  assign bit_end  = (cnt_q == CNT_LAST);

  always_comb begin
    wptr_d  = wr_en ? wptr_q + PW'(1) : wptr_q;
    rptr_d  = pop ? rptr_q + PW'(1) : rptr_q;
    count_d = count_q + CW'(wr_en) - CW'(pop);
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 16'd1;
    bit_d     = bit_q;
    shift_d   = shift_q;
    par_d     = par_q;
    pop       = 1'b0;
    frame_end = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (count_q != '0) begin
          pop     = 1'b1;
          state_d = START;
        end
      end
      START: begin
        if (bit_end) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_d   = '0;
          shift_d = shift_q >> 1;
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            bit_d   = '0;
            state_d = (PARITY_EN != 0) ? PARITY : STOP;
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          cnt_d = '0;
          bit_d = bit_q + 3'd1;
          if (bit_q == STOP_LAST) begin
            frame_end = 1'b1;
            bit_d     = '0;
            if (count_q != '0) begin
              pop     = 1'b1;
              state_d = START;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    if (pop) begin
      shift_d = mem_q[rptr_q];
      par_d   = (^mem_q[rptr_q]) ^ PAR_ODD;
    end
  end

  // Tx is the registered line level of the state being entered.
  always_comb begin
    tx_d = 1'b1;
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = par_d;
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE) || (count_d != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      if (wr_en) begin
        mem_q[wptr_q] <= datain;
      end
    end
  end

  assign Tx        = tx_q;
  assign busy      = busy_q;
  assign EnableOut = frame_end;

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
UART transmitter that serialises bytes onto a single Tx line using 8 data bits, LSB first, optional parity, and 1 or 2 stop bits. A small FIFO buffers bytes from the control logic, so several bytes can be queued while a frame is on the wire. It drives the line read by the board-side UART receiver at the same bit rate, 427 clk per bit (115200 baud).

Parameters:
CLKS_PER_BIT, 427, clk cycles per bit; legal range 2..65535; bit counter 16 bit
FIFO_DEPTH, 4, byte buffer entries; power of 2, 2..16
PARITY_EN, 0, 1 inserts a parity bit after data bit 7
PARITY_ODD, 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN=0
STOP_BITS, 1, number of stop bits, 1 or 2

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
datain  input  8  byte to queue
EnableIn  input  1  write strobe; datain is captured on any clk edge where EnableIn=1 and full=0
Tx  output  1  serial line, idles high
busy  output  1  high while a frame is on the line or the FIFO is not empty
full  output  1  FIFO holds FIFO_DEPTH bytes
overflow  output  1  one-cycle pulse when a write is dropped because full=1
EnableOut  output  1  one-cycle pulse at the end of each frame's last stop bit

Behaviour:
- Reset (async, rst_n=0): Tx=1, busy=0, full=0, overflow=0, EnableOut=0. FIFO is flushed, FSM goes to IDLE, bit counter is 0. A reset mid-frame aborts the frame, and Tx returns high immediately without waiting for a clk edge.
- FIFO: registered occupancy count, 0..FIFO_DEPTH; full = (count==FIFO_DEPTH).
  - Write while full is ignored, even if a pop occurs in the same cycle; overflow pulses in that cycle.
  - Write and pop in the same cycle with count<FIFO_DEPTH: both take effect and count is unchanged.
  - Pop from an empty FIFO never occurs.
  - Read and write pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: Tx=1. If the FIFO is not empty, pop the head byte into the shift register and go to START. Tx=0 is registered on that same edge.
  - START: Tx=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: Tx=shift[0] for CLKS_PER_BIT cycles per bit, shifting right; after bit 7, go to PARITY if PARITY_EN, else STOP.
  - PARITY: Tx = XOR of the 8 data bits, XOR PARITY_ODD, for CLKS_PER_BIT cycles.
  - STOP: Tx=1 for STOP_BITS*CLKS_PER_BIT cycles.
- End of frame: on the final STOP cycle, EnableOut is pulsed for 1 cycle. If the FIFO is not empty, pop the next byte and enter START directly, with no idle gap. Otherwise go to IDLE.
- Bit timing: the counter runs 0..CLKS_PER_BIT-1, and each bit is exactly CLKS_PER_BIT cycles.
  - Frame length = (10 + PARITY_EN + STOP_BITS - 1) * CLKS_PER_BIT cycles.
  - No drift is allowed across back-to-back frames.
- Latency: with the FIFO empty and FSM IDLE, a write on edge N makes Tx fall on edge N+1, one cycle after the write.
- busy = (FSM != IDLE) OR (count != 0), registered, and it drops in the cycle after the last stop bit when nothing is queued.
- The shift register is loaded only at a pop. FIFO contents never alter the frame in progress.
- EnableIn asserted for k consecutive cycles queues k bytes, limited by free space.

Test Plan:
- Single byte, CLKS_PER_BIT=4, 8N1: write 0xA5 -> Tx sequence 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles. Tx falls 1 cycle after the write, EnableOut pulses at cycle 40 of the frame, and busy is low the next cycle.
- Parity: PARITY_EN=1, PARITY_ODD=0, write 0xA5 -> parity bit 0. With PARITY_ODD=1, parity bit 1. With data 0x01 and even parity, parity bit 1. Frame length 44 cycles.
- Back-to-back with 2 stop bits: write 0x00, 0xFF, 0x55 on 3 consecutive cycles -> three frames, each 11*4 cycles. The next start bit follows the last stop-bit cycle with no gap. EnableOut pulses 3 times, 44 cycles apart.
- Overflow, FIFO_DEPTH=4: during a frame, write 6 bytes in consecutive cycles -> the first 4 are accepted and full goes high. Writes 5 and 6 are dropped with overflow pulsing twice. Only the 4 accepted bytes appear on Tx, in order.
- Simultaneous write and pop at full: with count=4, write on the cycle the FSM pops -> the write is dropped, overflow pulses, and count becomes 3.
- Reset mid-frame: assert rst_n=0 during data bit 3 -> Tx goes 1 asynchronously, busy=0, FIFO empty. After release with no writes, Tx stays 1 and no EnableOut pulse occurs.
